// File: rtl/mtime_ctrl_pkg.sv
// Shared definitions for the machine-timer block: register word map and time base.
package mtime_ctrl_pkg;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  // Nominal rate of clk_real_time_i, i.e. mtime increments per second.
  localparam int unsigned MTIME_FREQUENCY = 32'd1_000_000;

  function automatic logic [31:0] ctrl_word(input logic enable);
    return {31'b0, enable};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes the slow real-time clock into clk_i and flags each rising edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so the counter moves on the edge right after the rise is seen.
  assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mtime_ctrl.sv
// 64-bit machine timer with compare interrupt and a single-cycle register port.
// Handshake: every cycle with req_i = 1 is one access; ack_o pulses exactly one cycle later.
module mtime_ctrl
  import mtime_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        clk_real_time_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        timer_irq_o
);

  logic        tick;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        enable_q, enable_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q;
  logic        wr_en;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk_sys_i),
    .rst_n_i(rst_n_i),
    .async_i(clk_real_time_i),
    .tick_o (tick)
  );

  assign wr_en = req_i & we_i;

  // A write to either mtime half replaces the increment entirely.
  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    enable_d = enable_q;
    if (tick && enable_q) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_en) begin
      case (addr_i)
        MTIME_LO:    mtime_d  = {mtime_q[63:32], wdata_i};
        MTIME_HI:    mtime_d  = {wdata_i, mtime_q[31:0]};
        MTIMECMP_LO: cmp_d    = {cmp_q[63:32], wdata_i};
        MTIMECMP_HI: cmp_d    = {wdata_i, cmp_q[31:0]};
        CTRL:        enable_d = wdata_i[0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    if (req_i && !we_i) begin
      case (addr_i)
        MTIME_LO:    rdata_d = mtime_q[31:0];
        MTIME_HI:    rdata_d = mtime_q[63:32];
        MTIMECMP_LO: rdata_d = cmp_q[31:0];
        MTIMECMP_HI: rdata_d = cmp_q[63:32];
        CTRL:        rdata_d = ctrl_word(enable_q);
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mtime_q  <= 64'd0;
      cmp_q    <= CMP_RESET;
      enable_q <= 1'b1;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      enable_q <= enable_d;
      ack_q    <= req_i;
      rdata_q  <= rdata_d;
      // Compares the committed registers, so irq trails any change by one cycle.
      irq_q    <= (mtime_q >= cmp_q);
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_mtime_ctrl.sv
// Randomized and directed bench for mtime_ctrl against a register-level reference model.
module tb_mtime_ctrl;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        rt;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        irq_o;

  int n_vec = 0;
  int n_err = 0;

  mtime_ctrl #(
    .SYNC_STAGES(2),
    .CMP_RESET  (CMP_RST)
  ) dut (
    .clk_sys_i      (clk),
    .rst_n_i        (rst_n),
    .clk_real_time_i(rt),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rdata_o        (rdata_o),
    .ack_o          (ack_o),
    .timer_irq_o    (irq_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // reference model: architectural registers plus a history of sampled real-time levels
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        rt_hist[$];
  logic        exp_ack;
  logic [31:0] exp_rdata;
  logic        exp_irq;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {31'b0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    exp_ack = 1'b0;
    exp_rdata = 32'd0;
    exp_irq = 1'b0;
    m_mtime = 64'd0;
    m_cmp = CMP_RST;
    m_en = 1'b1;
    rt_hist = '{1'b0, 1'b0, 1'b0};
  end

  always @(posedge clk) begin
    logic tick;
    if (!rst_n) begin
      m_mtime = 64'd0;
      m_cmp = CMP_RST;
      m_en = 1'b1;
      rt_hist = '{1'b0, 1'b0, 1'b0};
      exp_ack = 1'b0;
      exp_rdata = 32'd0;
      exp_irq = 1'b0;
    end else begin
      // a rise sampled two edges ago, after a low three edges ago, counts now
      tick = rt_hist[1] && !rt_hist[2];
      exp_irq = (m_mtime >= m_cmp);
      exp_ack = req;
      exp_rdata = (req && !we) ? model_read(addr) : 32'd0;
      if (req && we && addr == 3'd0) m_mtime = {m_mtime[63:32], wdata};
      else if (req && we && addr == 3'd1) m_mtime = {wdata, m_mtime[31:0]};
      else if (tick && m_en) m_mtime = m_mtime + 64'd1;
      if (req && we && addr == 3'd2) m_cmp = {m_cmp[63:32], wdata};
      if (req && we && addr == 3'd3) m_cmp = {wdata, m_cmp[31:0]};
      if (req && we && addr == 3'd4) m_en = wdata[0];
      rt_hist.push_front(rt);
      void'(rt_hist.pop_back());
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ack", ack_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_irq", irq_o, 1'b0);
    end else begin
      chk("ack", ack_o, exp_ack);
      chk("rdata", rdata_o, exp_rdata);
      chk("irq", irq_o, exp_irq);
    end
  end

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic cyc(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    req = r;
    we = w;
    addr = a;
    wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cyc(1'b1, 1'b0, a, 32'd0);
    d = rdata_o;
  endtask

  task automatic rt_period();
    rt = 1'b1;
    idle(4);
    rt = 1'b0;
    idle(4);
  endtask

  logic [31:0] d, r1, r2, r3, r4;
  logic [31:0] burst_exp[5];

  initial begin
    rst_n = 1'b0;
    rt = 1'b0;
    req = 1'b0;
    we = 1'b0;
    addr = 3'd0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    rd(3'd0, d); chk("reset_mtime_lo", d, 32'd0);
    rd(3'd2, d); chk("reset_cmp_lo", d, 32'hFFFF_FFFF);
    rd(3'd4, d); chk("reset_ctrl", d, 32'd1);

    // five real-time periods
    for (int i = 0; i < 5; i++) rt_period();
    idle(3);
    rd(3'd0, d); chk("five_ticks", d, 32'd5);

    // increment lands on the third edge after the rise is sampled
    rt = 1'b1;
    rd(3'd0, r1);
    rd(3'd0, r2);
    rd(3'd0, r3);
    rd(3'd0, r4);
    chk("tick_lat_e2", r2, 32'd5);
    chk("tick_lat_e3", r3, 32'd5);
    chk("tick_lat_e4", r4, 32'd6);
    rt = 1'b0;
    idle(4);

    // carry and wrap
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    rt_period();
    rd(3'd0, d); chk("carry_lo", d, 32'd0);
    rd(3'd1, d); chk("carry_hi", d, 32'd1);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    rt_period();
    rd(3'd0, d); chk("wrap_lo", d, 32'd0);
    rd(3'd1, d); chk("wrap_hi", d, 32'd0);

    // compare interrupt
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd8);
    rt_period();
    chk("irq_at_9", irq_o, 1'b0);
    rt_period();
    chk("irq_at_10", irq_o, 1'b1);
    wr(3'd2, 32'd100);
    chk("irq_hold_after_wr", irq_o, 1'b1);
    idle(1);
    chk("irq_fall", irq_o, 1'b0);

    // write beats a same-cycle tick
    rt = 1'b1;
    idle(2);
    wr(3'd0, 32'h55);
    rt = 1'b0;
    idle(4);
    rd(3'd0, d); chk("wr_beats_tick_lo", d, 32'h55);
    rd(3'd1, d); chk("wr_beats_tick_hi", d, 32'd0);

    // disabled counter
    wr(3'd4, 32'hFFFF_FFFE);
    rt_period();
    rt_period();
    rd(3'd0, d); chk("frozen", d, 32'h55);
    rd(3'd4, d); chk("ctrl_disabled", d, 32'd0);
    rd(3'd6, d); chk("unmapped_rd", d, 32'd0);
    wr(3'd7, 32'h1234);
    wr(3'd4, 32'd1);

    // back-to-back reads
    wr(3'd2, 32'd0);
    idle(2);
    burst_exp = '{32'h55, 32'd0, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), d);
      chk("burst_ack", ack_o, 1'b1);
      chk("burst_data", d, burst_exp[i]);
    end
    idle(1);
    chk("irq_before_rst", irq_o, 1'b1);

    // reset in the middle of a burst
    cyc(1'b1, 1'b0, 3'd0, 32'd0);
    cyc(1'b1, 1'b0, 3'd1, 32'd0);
    req = 1'b1;
    addr = 3'd2;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack_o, 1'b0);
    chk("midrst_rdata", rdata_o, 32'd0);
    chk("midrst_irq", irq_o, 1'b0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("no_trailing_ack", ack_o, 1'b0);
    rd(3'd2, d); chk("post_rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(3'd3, d); chk("post_rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(3'd0, d); chk("post_rst_mtime", d, 32'd0);
    rd(3'd4, d); chk("post_rst_ctrl", d, 32'd1);

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) rt = ~rt;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)));
    end
    rt = 1'b0;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mtime_ctrl.md
MTIME_CTRL -- requirements
Module: mtime_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on clk_real_time_i, range 2..3.
REQ-002 SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.
REQ-003 SHALL have port clk_sys_i, input, 1: the single system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clk_real_time_i, input, 1: slow divided time-base clock; treated as asynchronous data.
REQ-006 SHALL have port req_i, input, 1: register access request, one access per asserted cycle.
REQ-007 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port addr_i, input, 3: word index; 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 ctrl; 5..7 unmapped.
REQ-009 SHALL have port wdata_i, input, 32: write data.
REQ-010 SHALL have port rdata_o, output, 32: read data, valid while ack_o = 1.
REQ-011 SHALL have port ack_o, output, 1: access-complete strobe.
REQ-012 SHALL have port timer_irq_o, output, 1: machine timer interrupt, level.

Function
REQ-013 SHALL pass clk_real_time_i through SYNC_STAGES flops, then a previous-value flop; tick = synchronized high AND previous low.
REQ-014 SHALL increment mtime (64-bit) by 1 on each clk_sys_i edge where tick = 1 and ctrl.enable (bit 0) = 1.
REQ-015 SHALL, with SYNC_STAGES = 2, update mtime on the 3rd clk_sys_i rising edge after clk_real_time_i is first sampled high.
REQ-016 SHALL wrap mtime from 2^64-1 to 0 with no flag and no stall.
REQ-017 SHALL carry low-word overflow into the high word in the same cycle.
REQ-018 SHALL ack every request exactly one cycle later: ack_o = 1 for one cycle, rdata_o registered with it.
REQ-019 SHALL accept back-to-back requests, one per cycle, with no wait states.
REQ-020 SHALL hold ack_o = 0 and rdata_o = 0 in cycles with no pending acknowledgement.
REQ-021 SHALL commit writes at the edge ending the request cycle, replacing only the addressed 32-bit half.
REQ-022 SHALL let a write to mtime_lo/hi win over a same-cycle tick; the written half takes wdata_i, the other half is unchanged and receives no increment or carry.
REQ-023 SHALL return, on a read, the register value before the edge that ends the request cycle.
REQ-024 SHALL ack an unmapped access with rdata_o = 0 and ignore it as a write.
REQ-025 SHALL read ctrl as {31'b0, enable}; writes to ctrl bits 31..1 are ignored.
REQ-026 SHALL register timer_irq_o = (mtime >= mtimecmp) as an unsigned compare of the post-update values, one cycle after any change.
REQ-027 SHALL NOT guard the compare during split 32-bit mtimecmp updates; glitch-free updates are software's responsibility.
REQ-028 SHALL leave timer_irq_o unaffected by ctrl.enable; only the comparison drives it.

Reset
REQ-029 SHALL, while rst_n_i = 0, immediately force: mtime = 0, mtimecmp = CMP_RESET, enable = 1, ack_o = 0, rdata_o = 0, timer_irq_o = 0, all synchronizer/edge flops = 0.
REQ-030 SHALL discard a request pending at reset assertion, with no ack after release.
REQ-031 SHALL not generate a tick on the first cycle after release even if clk_real_time_i is high; edge flops start at 0, so the first rise is counted only after sync.

Structure
REQ-032 SHALL take the register word-index constants (MTIME_LO..CTRL) and the MTIME_FREQUENCY time base from the shared QianTang header.
REQ-033 SHALL put synchronizer plus rising-edge detect in one sub-module, sync_edge, parameterized by SYNC_STAGES; the register file, counter and compare stay in mtime_ctrl.

Verification
REQ-034 Toggle clk_real_time_i 5 full periods, enable = 1 -> mtime reads 5; each increment lands 3 clk_sys_i edges after the rise.
REQ-035 Write mtime_hi = 0, mtime_lo = FFFF_FFFF, one tick -> mtime_lo = 0, mtime_hi = 1; preset 2^64-1 plus one tick -> both words 0.
REQ-036 mtimecmp = 10, mtime counting from 8 -> timer_irq_o rises one cycle after mtime becomes 10; rewrite mtimecmp_lo = 100 -> irq falls one cycle after the write.
REQ-037 Write mtime_lo = 0x55 in the same cycle as a tick -> mtime_lo = 0x55, no increment; write ctrl = 0, then ticks -> mtime frozen; read addr 6 -> ack with 0.
REQ-038 Back-to-back reads of addr 0..4 on 5 consecutive cycles -> 5 consecutive one-cycle acks, correct data; assert rst_n_i mid-burst -> outputs cleared at once, mtimecmp = FFFF_FFFF_FFFF_FFFF, no trailing ack.
